field_dispatch: RTL and testbench
=================================

Name: field_dispatch

Overview:
- Front-end splitter for the protobuf decode pipeline.
- Pops raw message bytes from the input FIFO and parses each field key. Routes field payload bytes to the varint path FIFO or the raw-data path FIFO, tagging every byte with a 10-bit field index.
- Field indices are sequential and wrap at 1023. The downstream output merger re-serialises fields by index, so indices are never skipped.

Parameters:
- IDX_W, 10, field index width; wraps from 2^IDX_W-1 to 0.
- LEN_W, 14, length register width; length varints of at most 2 bytes are supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_fifo_empty  in  1  input byte FIFO empty
- in_fifo_q  in  8  input FIFO head byte (show-ahead, valid when !empty)
- in_fifo_pop  out  1  pop input FIFO head
- varint_fifo_full  in  1  varint path FIFO full
- varint_fifo_push  out  1  write varint byte
- varint_fifo_d  out  8  varint byte (= in_fifo_q)
- varint_index_d  out  IDX_W  field index of pushed varint byte
- varint_last  out  1  pushed byte ends the field
- raw_fifo_full  in  1  raw path FIFO full
- raw_fifo_push  out  1  write raw byte
- raw_fifo_d  out  8  raw byte (= in_fifo_q)
- raw_index_d  out  IDX_W  field index of pushed raw byte
- raw_last  out  1  pushed byte ends the field
- error  out  1  sticky parse error; cleared only by reset

Behaviour:
- Clock and reset:
  - One clock domain. Synchronous active-high reset puts the FSM in INIT and clears the length counter.
  - While reset is high and in INIT, all push/pop outputs are 0 and error is 0.
- Output timing:
  - Outputs are combinational from state, the registered index, and the FIFO status inputs.
  - A byte pop and its path push occur in the same cycle. One byte moves per cycle, maximum.
- State machine, one-hot: INIT, KEY, KEY_CONT, VARINT, LEN0, LEN1, RAW, ERR.
- INIT: clear index to 0, then go to KEY.
- KEY: on !in_fifo_empty, pop. wt = in_fifo_q[2:0].
  - If in_fifo_q[7]=1, go to KEY_CONT; the wire type is already latched.
  - Otherwise dispatch on wt:
    - 0 -> VARINT
    - 1 -> RAW, cnt=8
    - 2 -> LEN0
    - 5 -> RAW, cnt=4
    - 3, 4, 6, 7 -> ERR
- KEY_CONT: pop and discard bytes while bit7=1. On a bit7=0 byte, pop it and dispatch on the latched wt.
- VARINT: when !empty && !varint_fifo_full, pop and push; varint_last = ~in_fifo_q[7].
  - On last, increment index and go to KEY.
  - More than 10 bytes in one varint -> ERR; the 11th byte is not popped.
- LEN0: pop; cnt = in_fifo_q[6:0].
  - If bit7=1, go to LEN1.
  - Else if cnt=0, go to KEY without incrementing index; empty fields consume no index.
  - Else go to RAW.
- LEN1: pop; cnt |= in_fifo_q[6:0]<<7.
  - If bit7=1 -> ERR.
  - Else if cnt=0 -> KEY.
  - Else -> RAW.
- RAW: when !empty && !raw_fifo_full, pop, push, decrement cnt; raw_last = (cnt==1).
  - On last, increment index and go to KEY.
- Index increment: index+1, with 2^IDX_W-1 -> 0. The new index is effective from the next cycle.
- Stall rules:
  - Empty input FIFO or full target FIFO stalls with no pop, no push, and state held. There is no partial transfer.
  - Full on the non-target FIFO is ignored.
- ERR: error=1, no pop or push, held until reset.
- Reset mid-field: abandons the field. Index returns to 0 via INIT; no last flag is emitted.
- Both push outputs are never high in the same cycle.

Test Plan:
- 1. Varint field. Bytes 08 96 01 -> varint pushes 96 (idx0, last0) then 01 (idx0, last1); index becomes 1; raw_fifo_push stays 0.
- 2. Length-delimited field. Bytes 12 03 61 62 63 -> raw pushes 61, 62, 63 all at idx0, last=1 on 63 only. Then 0D + 4 bytes -> 4 raw pushes at idx1.
- 3. Backpressure. Hold varint_fifo_full=1 for 5 cycles mid-varint -> in_fifo_pop=0 and no push during the stall; the byte sequence is intact after release.
- 4. Wrap and empty fields. Send 1025 single-byte varint fields -> field 1023 tagged idx 1023, field 1024 tagged idx 0. Insert 12 00 between fields -> no push, index unchanged.
- 5. Errors and reset. Key 0B (wt 3) -> error=1 next cycle, pops cease. Reset mid-RAW -> error=0, index 0, next key parsed correctly.

Source files
------------

// File: rtl/field_dispatch.sv
// Protobuf front-end splitter: parses field keys and steers payload bytes to
// the varint or raw-data path, tagging each byte with a sequential field index.
module field_dispatch #(
  parameter int IDX_W = 10,
  parameter int LEN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_fifo_empty,
  input  logic [7:0]       in_fifo_q,
  output logic             in_fifo_pop,
  input  logic             varint_fifo_full,
  output logic             varint_fifo_push,
  output logic [7:0]       varint_fifo_d,
  output logic [IDX_W-1:0] varint_index_d,
  output logic             varint_last,
  input  logic             raw_fifo_full,
  output logic             raw_fifo_push,
  output logic [7:0]       raw_fifo_d,
  output logic [IDX_W-1:0] raw_index_d,
  output logic             raw_last,
  output logic             error
);

  localparam logic [7:0] S_INIT     = 8'b0000_0001;
  localparam logic [7:0] S_KEY      = 8'b0000_0010;
  localparam logic [7:0] S_KEY_CONT = 8'b0000_0100;
  localparam logic [7:0] S_VARINT   = 8'b0000_1000;
  localparam logic [7:0] S_LEN0     = 8'b0001_0000;
  localparam logic [7:0] S_LEN1     = 8'b0010_0000;
  localparam logic [7:0] S_RAW      = 8'b0100_0000;
  localparam logic [7:0] S_ERR      = 8'b1000_0000;

  localparam logic [3:0] VARINT_MAX = 4'd10;

  logic [7:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [2:0]       wt_q, wt_d;
  logic [3:0]       vcnt_q, vcnt_d;

  logic             have_byte;
  logic             disp;
  logic [2:0]       disp_wt;

  // Nothing moves while reset is held, so an abandoned field emits no last flag.
  assign have_byte = !in_fifo_empty && !reset;

  assign varint_fifo_d  = in_fifo_q;
  assign raw_fifo_d     = in_fifo_q;
  assign varint_index_d = idx_q;
  assign raw_index_d    = idx_q;
  assign error          = (state_q == S_ERR);

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    wt_d             = wt_q;
    vcnt_d           = vcnt_q;
    in_fifo_pop      = 1'b0;
    varint_fifo_push = 1'b0;
    raw_fifo_push    = 1'b0;
    varint_last      = 1'b0;
    raw_last         = 1'b0;
    disp             = 1'b0;
    disp_wt          = 3'd0;

    case (state_q)
      S_INIT: begin
        idx_d   = '0;
        state_d = S_KEY;
      end
      S_KEY: begin
        if (have_byte) begin
          in_fifo_pop = 1'b1;
          wt_d        = in_fifo_q[2:0];
          if (in_fifo_q[7]) begin
            state_d = S_KEY_CONT;
          end else begin
            disp    = 1'b1;
            disp_wt = in_fifo_q[2:0];
          end
        end
      end
      S_KEY_CONT: begin
        // Upper field-number bytes carry no routing information.
        if (have_byte) begin
          in_fifo_pop = 1'b1;
          if (!in_fifo_q[7]) begin
            disp    = 1'b1;
            disp_wt = wt_q;
          end
        end
      end
      S_VARINT: begin
        if (vcnt_q == VARINT_MAX) begin
          state_d = S_ERR;
        end else if (have_byte && !varint_fifo_full) begin
          in_fifo_pop      = 1'b1;
          varint_fifo_push = 1'b1;
          varint_last      = ~in_fifo_q[7];
          vcnt_d           = vcnt_q + 4'd1;
          if (!in_fifo_q[7]) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_KEY;
          end
        end
      end
      S_LEN0: begin
        if (have_byte) begin
          in_fifo_pop = 1'b1;
          cnt_d       = LEN_W'(in_fifo_q[6:0]);
          if (in_fifo_q[7])                state_d = S_LEN1;
          else if (in_fifo_q[6:0] == 7'd0) state_d = S_KEY;
          else                             state_d = S_RAW;
        end
      end
      S_LEN1: begin
        if (have_byte) begin
          in_fifo_pop = 1'b1;
          cnt_d       = cnt_q | (LEN_W'(in_fifo_q[6:0]) << 7);
          if (in_fifo_q[7])     state_d = S_ERR;
          else if (cnt_d == '0) state_d = S_KEY;
          else                  state_d = S_RAW;
        end
      end
      S_RAW: begin
        if (have_byte && !raw_fifo_full) begin
          in_fifo_pop   = 1'b1;
          raw_fifo_push = 1'b1;
          raw_last      = (cnt_q == LEN_W'(1));
          cnt_d         = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_KEY;
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase

    // Shared wire-type dispatch for single-byte and multi-byte keys.
    if (disp) begin
      vcnt_d = 4'd0;
      case (disp_wt)
        3'd0: state_d = S_VARINT;
        3'd1: begin
          state_d = S_RAW;
          cnt_d   = LEN_W'(8);
        end
        3'd2: state_d = S_LEN0;
        3'd5: begin
          state_d = S_RAW;
          cnt_d   = LEN_W'(4);
        end
        default: state_d = S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      wt_q    <= 3'd0;
      vcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wt_q    <= wt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // Index is deliberately not reset here: INIT clears it on the way out of reset.
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
  end

endmodule

// File: tb/tb_field_dispatch.sv
// Directed bench for field_dispatch: a queue-backed input FIFO feeds bytes,
// every path push is logged and compared against hand-written expectations.
module tb_field_dispatch;
  localparam int IDX_W = 10;
  localparam int LEN_W = 14;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_fifo_empty = 1'b1;
  logic [7:0]       in_fifo_q = 8'h00;
  logic             in_fifo_pop;
  logic             varint_fifo_full = 1'b0;
  logic             varint_fifo_push;
  logic [7:0]       varint_fifo_d;
  logic [IDX_W-1:0] varint_index_d;
  logic             varint_last;
  logic             raw_fifo_full = 1'b0;
  logic             raw_fifo_push;
  logic [7:0]       raw_fifo_d;
  logic [IDX_W-1:0] raw_index_d;
  logic             raw_last;
  logic             error;

  always #5 clk = ~clk;

  field_dispatch #(.IDX_W(IDX_W), .LEN_W(LEN_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_fifo_empty    (in_fifo_empty),
    .in_fifo_q        (in_fifo_q),
    .in_fifo_pop      (in_fifo_pop),
    .varint_fifo_full (varint_fifo_full),
    .varint_fifo_push (varint_fifo_push),
    .varint_fifo_d    (varint_fifo_d),
    .varint_index_d   (varint_index_d),
    .varint_last      (varint_last),
    .raw_fifo_full    (raw_fifo_full),
    .raw_fifo_push    (raw_fifo_push),
    .raw_fifo_d       (raw_fifo_d),
    .raw_index_d      (raw_index_d),
    .raw_last         (raw_last),
    .error            (error)
  );

  logic [7:0]       in_q[$];
  logic [19:0]      log_q[$];
  logic [19:0]      exp_q[$];
  logic [IDX_W-1:0] exp_idx = '0;
  logic             mon_pop = 1'b0;
  int               total = 0;
  int               bad = 0;
  int               both_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    in_fifo_empty = (in_q.size() == 0);
    in_fifo_q     = in_fifo_empty ? 8'h00 : in_q[0];
  endtask

  // Sample outputs at negedge; retire the popped head just after the next posedge.
  always begin
    @(negedge clk);
    if (varint_fifo_push && raw_fifo_push) both_cnt++;
    if (varint_fifo_push) log_q.push_back({1'b0, varint_last, varint_index_d, varint_fifo_d});
    if (raw_fifo_push)    log_q.push_back({1'b1, raw_last, raw_index_d, raw_fifo_d});
    mon_pop = in_fifo_pop;
    @(posedge clk);
    #1;
    if (mon_pop && in_q.size() > 0) void'(in_q.pop_front());
    refresh();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [7:0] b);
    in_q.push_back(b);
    refresh();
  endtask

  task automatic ev(input logic [7:0] d, input logic last);
    exp_q.push_back({1'b0, last, exp_idx, d});
    if (last) exp_idx++;
  endtask

  task automatic er(input logic [7:0] d, input logic last);
    exp_q.push_back({1'b1, last, exp_idx, d});
    if (last) exp_idx++;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (in_q.size() != 0 && n < 4000) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, in_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_q.delete();
    refresh();
    repeat (3) tick();
    reset = 1'b0;
    exp_idx = '0;
    log_q.delete();
    exp_q.delete();
    tick();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pop", in_fifo_pop, 0);
    chk("rst_vpush", varint_fifo_push, 0);
    chk("rst_rpush", raw_fifo_push, 0);
    chk("rst_error", error, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single varint field
    put(8'h08); put(8'h96); put(8'h01);
    ev(8'h96, 1'b0); ev(8'h01, 1'b1);
    drain("t1");
    check_log("t1");

    // Length-delimited, fixed32/64, multi-byte key, empty field, 2-byte length
    put(8'h12); put(8'h03); put(8'h61); put(8'h62); put(8'h63);
    er(8'h61, 1'b0); er(8'h62, 1'b0); er(8'h63, 1'b1);
    put(8'h0D); put(8'hA0); put(8'hA1); put(8'hA2); put(8'hA3);
    er(8'hA0, 1'b0); er(8'hA1, 1'b0); er(8'hA2, 1'b0); er(8'hA3, 1'b1);
    put(8'h09);
    for (int j = 0; j < 8; j++) begin
      put(8'h10 + 8'(j));
      er(8'h10 + 8'(j), j == 7);
    end
    put(8'h88); put(8'h01); put(8'h05);
    ev(8'h05, 1'b1);
    put(8'h12); put(8'h00);
    put(8'h08); put(8'h06);
    ev(8'h06, 1'b1);
    put(8'h12); put(8'h81); put(8'h01);
    for (int j = 0; j < 129; j++) begin
      put(8'(j));
      er(8'(j), j == 128);
    end
    drain("t2");
    check_log("t2");

    // Backpressure mid-varint, raw path full throughout (non-target)
    raw_fifo_full = 1'b1;
    put(8'h08); put(8'h96);
    drain("t3a");
    varint_fifo_full = 1'b1;
    put(8'h80); put(8'h01);
    repeat (5) begin
      @(negedge clk);
      chk("stall_pop", in_fifo_pop, 0);
      chk("stall_push", varint_fifo_push, 0);
    end
    tick();
    chk("stall_hold", in_q.size(), 2);
    varint_fifo_full = 1'b0;
    ev(8'h96, 1'b0); ev(8'h80, 1'b0); ev(8'h01, 1'b1);
    drain("t3b");
    check_log("t3");
    raw_fifo_full = 1'b0;

    // Index wrap with interleaved empty fields
    do_reset();
    for (int i = 0; i < 1025; i++) begin
      put(8'h08);
      put({1'b0, 7'(i)});
      ev({1'b0, 7'(i)}, 1'b1);
      if (i == 3) begin
        put(8'h12); put(8'h00);
        put(8'h12); put(8'h80); put(8'h00);
      end
    end
    drain("t4");
    check_log("t4");

    // Bad wire type: error next cycle, pops cease
    do_reset();
    put(8'h0B);
    @(negedge clk);
    chk("errkey_pop", in_fifo_pop, 1);
    chk("errkey_early", error, 0);
    @(negedge clk);
    chk("errkey_flag", error, 1);
    tick();
    put(8'h08); put(8'h01);
    repeat (5) tick();
    chk("errkey_nopop", in_q.size(), 2);
    chk("errkey_sticky", error, 1);
    check_log("errkey");

    // Varint longer than 10 bytes: 11th byte stays in the FIFO
    do_reset();
    put(8'h08);
    for (int j = 0; j < 10; j++) begin
      put(8'h80);
      ev(8'h80, 1'b0);
    end
    put(8'h01);
    repeat (20) tick();
    chk("longvar_err", error, 1);
    chk("longvar_left", in_q.size(), 1);
    check_log("longvar");

    // Length varint longer than 2 bytes
    do_reset();
    put(8'h12); put(8'h80); put(8'h80);
    repeat (8) tick();
    chk("len3_err", error, 1);
    chk("len3_left", in_q.size(), 0);
    check_log("len3");

    // Reset mid-RAW, then a clean field from index 0
    do_reset();
    put(8'h12); put(8'h05); put(8'hB1); put(8'hB2);
    er(8'hB1, 1'b0); er(8'hB2, 1'b0);
    drain("midraw");
    check_log("midraw");
    do_reset();
    @(negedge clk);
    chk("midraw_error", error, 0);
    tick();
    put(8'h08); put(8'h7F);
    ev(8'h7F, 1'b1);
    drain("after");
    check_log("after");

    chk("both_push", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
